// File: rtl/tflaf_pkg.sv
// Shared types and defaults for the tflaf run sequencer.
package tflaf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRST  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } run_state_e;

    localparam int TFLAF_WIDTH = 16;
    localparam int TFLAF_RET   = 4;
    localparam int TRIAL_IDX_W = 8;

endpackage

// File: rtl/tflaf_run_ctrl_if.sv
// Upstream (x, d) sample stream: valid from the source, ready from the sequencer.
interface tflaf_run_ctrl_if #(
    parameter int WIDTH = tflaf_pkg::TFLAF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_d;

    modport master (output in_valid, output in_x, output in_d, input in_ready);
    modport slave  (input in_valid, input in_x, input in_d, output in_ready);
endinterface

// File: rtl/tflaf_valid_pipe.sv
// DEPTH-stage shift of {valid, last} tracking samples through the filter.
// Fixed DEPTH-cycle latency, never stalls; clr_i empties every stage.
module tflaf_valid_pipe #(
    parameter int DEPTH = tflaf_pkg::TFLAF_RET
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic vld_i,
    input  logic last_i,
    output logic vld_o,
    output logic last_o
);
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            last_q <= '0;
        end else if (clr_i) begin
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            vld_q  <= (vld_q << 1) | DEPTH'(vld_i);
            last_q <= (last_q << 1) | DEPTH'(last_i & vld_i);
        end
    end

    assign vld_o  = vld_q[DEPTH-1];
    assign last_o = last_q[DEPTH-1];
endmodule

// File: rtl/tflaf_run_ctrl.sv
// Trial sequencer for tflaf_top: reset, stream N samples, flush; error tagged RET+1 edges after accept.
// The filter is never stalled: a missing upstream sample becomes a zero bubble and sets underflow.
module tflaf_run_ctrl
    import tflaf_pkg::*;
#(
    parameter int WIDTH     = TFLAF_WIDTH,
    parameter int N         = 25000,
    parameter int NUM_TRIAL = 50,
    parameter int RET       = TFLAF_RET,
    parameter int RST_CYC   = 2,
    parameter int CNT_W     = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    tflaf_run_ctrl_if.slave        up,
    output logic                   filt_rst,
    output logic [WIDTH-1:0]       signal_in,
    output logic [WIDTH-1:0]       desired_in,
    input  logic [WIDTH-1:0]       error_d_in,
    output logic [WIDTH-1:0]       err_out,
    output logic                   err_valid,
    output logic                   err_last,
    output logic [TRIAL_IDX_W-1:0] trial_idx,
    output logic                   busy,
    output logic                   trial_done,
    output logic                   all_done,
    output logic                   underflow
);
    localparam int PH_W = 8;

    run_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [PH_W-1:0]        ph_q, ph_d;
    logic [TRIAL_IDX_W-1:0] trial_q, trial_d;
    logic [WIDTH-1:0]       sig_q, sig_d, des_q, des_d, err_q;
    logic                   s0_vld_q, s0_vld_d, s0_last_q, s0_last_d;
    logic                   err_vld_q, err_last_q;
    logic                   trial_done_q, trial_done_d;
    logic                   all_done_q, all_done_d;
    logic                   unf_q, unf_d;
    logic                   pipe_vld, pipe_last;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ph_d         = ph_q;
        trial_d      = trial_q;
        sig_d        = '0;
        des_d        = '0;
        s0_vld_d     = 1'b0;
        s0_last_d    = 1'b0;
        trial_done_d = 1'b0;
        all_done_d   = 1'b0;
        unf_d        = unf_q;
        cnt_inc      = cnt_q + CNT_W'(1);

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = FRST;
                        ph_d    = '0;
                        trial_d = '0;
                        unf_d   = 1'b0;
                    end
                end
                FRST: begin
                    if (ph_q == PH_W'(RST_CYC - 1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        ph_d = ph_q + PH_W'(1);
                    end
                end
                RUN: begin
                    if (up.in_valid) begin
                        sig_d    = up.in_x;
                        des_d    = up.in_d;
                        s0_vld_d = 1'b1;
                        cnt_d    = cnt_inc;
                        if (cnt_inc == CNT_W'(N)) begin
                            s0_last_d = 1'b1;
                            state_d   = FLUSH;
                            ph_d      = '0;
                        end
                    end else begin
                        unf_d = 1'b1;
                    end
                end
                FLUSH: begin
                    // RET+1 bubbles drain the filter and the output register.
                    if (ph_q == PH_W'(RET)) begin
                        trial_done_d = 1'b1;
                        trial_d      = trial_q + TRIAL_IDX_W'(1);
                        if (trial_q == TRIAL_IDX_W'(NUM_TRIAL - 1)) begin
                            all_done_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            state_d = FRST;
                            ph_d    = '0;
                        end
                    end else begin
                        ph_d = ph_q + PH_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ph_q         <= '0;
            trial_q      <= '0;
            sig_q        <= '0;
            des_q        <= '0;
            s0_vld_q     <= 1'b0;
            s0_last_q    <= 1'b0;
            err_q        <= '0;
            err_vld_q    <= 1'b0;
            err_last_q   <= 1'b0;
            trial_done_q <= 1'b0;
            all_done_q   <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ph_q         <= ph_d;
            trial_q      <= trial_d;
            sig_q        <= sig_d;
            des_q        <= des_d;
            s0_vld_q     <= s0_vld_d;
            s0_last_q    <= s0_last_d;
            err_q        <= error_d_in;
            err_vld_q    <= pipe_vld & ~abort;
            err_last_q   <= pipe_vld & pipe_last & ~abort;
            trial_done_q <= trial_done_d;
            all_done_q   <= all_done_d;
            unf_q        <= unf_d;
        end
    end

    // s0 travels with signal_in, so the pipe only has to cover the filter's RET cycles.
    tflaf_valid_pipe #(.DEPTH(RET)) u_vpipe (
        .clk    (clk),
        .rst    (reset),
        .clr_i  (abort),
        .vld_i  (s0_vld_q),
        .last_i (s0_last_q),
        .vld_o  (pipe_vld),
        .last_o (pipe_last)
    );

    assign filt_rst    = (state_q == IDLE) || (state_q == FRST);
    assign up.in_ready = (state_q == RUN) && !abort;
    assign busy        = (state_q != IDLE);
    assign signal_in   = sig_q;
    assign desired_in  = des_q;
    assign err_out     = err_q;
    assign err_valid   = err_vld_q;
    assign err_last    = err_last_q;
    assign trial_idx   = trial_q;
    assign trial_done  = trial_done_q;
    assign all_done    = all_done_q;
    assign underflow   = unf_q;
endmodule

// File: tb/tb_tflaf_run_ctrl.sv
// Bench for tflaf_run_ctrl: source driver, RET-cycle filter stand-in, scoreboard on err_valid.
module tb_tflaf_run_ctrl;
    localparam int W = 16, N = 8, NUM_TRIAL = 2, RET = 4, RST_CYC = 2, CNT_W = 4;

    logic clk = 1'b0, reset, start, abort;
    logic filt_rst, err_valid, err_last, busy, trial_done, all_done, underflow;
    logic [W-1:0] signal_in, desired_in, error_d_in, err_out;
    logic [7:0] trial_idx;

    tflaf_run_ctrl_if #(.WIDTH(W)) up_if ();

    tflaf_run_ctrl #(.WIDTH(W), .N(N), .NUM_TRIAL(NUM_TRIAL), .RET(RET),
                     .RST_CYC(RST_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .up(up_if.slave),
        .filt_rst(filt_rst), .signal_in(signal_in), .desired_in(desired_in),
        .error_d_in(error_d_in), .err_out(err_out), .err_valid(err_valid),
        .err_last(err_last), .trial_idx(trial_idx), .busy(busy),
        .trial_done(trial_done), .all_done(all_done), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [W-1:0] val; logic last; logic [31:0] cyc; } exp_t;
    exp_t sb[$];
    int n_chk = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Filter stand-in: error word appears RET cycles after the sample on signal_in.
    logic [W-1:0] dl [RET];
    always @(posedge clk) begin
        dl[0] <= signal_in ^ desired_in ^ 16'h5A00;
        for (int i = 1; i < RET; i++) dl[i] <= dl[i-1];
    end
    assign error_d_in = dl[RET-1];

    logic [31:0] cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int acc_in_trial = 0, gap_after = 0, gap_len = 2, gap_cnt = 0;
    bit src_en = 0, prev_acc = 0, prev_bub = 0;
    logic [W-1:0] x_next = 1, prev_x = 0;

    initial begin
        exp_t e;
        up_if.in_valid = 1'b0; up_if.in_x = '0; up_if.in_d = '0;
        forever begin
            @(negedge clk);
            if (prev_acc) begin
                chk("sig_in", signal_in, prev_x);
                chk("des_in", desired_in, prev_x + 16'h0100);
            end
            if (prev_bub) begin
                chk("sig_bubble", signal_in, 0);
                chk("unf_set", underflow, 1);
            end
            prev_acc = 0; prev_bub = 0;
            if (gap_cnt > 0) begin up_if.in_valid = 1'b0; gap_cnt--; end
            else up_if.in_valid = src_en;
            up_if.in_x = x_next;
            up_if.in_d = x_next + 16'h0100;
            #1;
            if (up_if.in_ready) begin
                if (up_if.in_valid) begin
                    e.val  = x_next ^ (x_next + 16'h0100) ^ 16'h5A00;
                    e.last = (acc_in_trial == N - 1);
                    e.cyc  = cyc + 1;
                    sb.push_back(e);
                    prev_acc = 1; prev_x = x_next; acc_in_trial++;
                    if (acc_in_trial == N) begin acc_in_trial = 0; x_next = 1; end
                    else x_next = x_next + 1;
                    if (gap_after != 0 && acc_in_trial == gap_after) gap_cnt = gap_len;
                end else prev_bub = 1;
            end
        end
    end

    int ev_total = 0, ev_trial = 0, run_td = 0, run_ad = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (err_valid) begin
                    ev_total++; ev_trial++;
                    chk("err_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("err_out", err_out, e.val);
                        chk("err_last", err_last, e.last);
                        chk("err_latency", cyc - e.cyc, RET + 1);
                    end
                end
                if (trial_done) begin
                    chk("trial_nerr", ev_trial, N);
                    chk("trial_idx_td", trial_idx, run_td + 1);
                    chk("all_done_td", all_done, run_td == NUM_TRIAL - 1);
                    ev_trial = 0; run_td++;
                end
                if (all_done) begin
                    chk("ad_with_td", trial_done, 1);
                    run_ad++;
                end
            end
        end
    end

    task automatic prep_run(input int gap);
        sb.delete(); acc_in_trial = 0; x_next = 1; gap_after = gap; gap_cnt = 0;
        ev_trial = 0; run_td = 0; run_ad = 0; src_en = 1;
    endtask

    task automatic start_run();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        chk("busy_frst", busy, 1); chk("frst_rst0", filt_rst, 1); chk("unf_cleared", underflow, 0);
        @(negedge clk);
        chk("frst_rst1", filt_rst, 1); chk("frst_rdy", up_if.in_ready, 0);
        @(negedge clk);
        chk("run_rst", filt_rst, 0); chk("run_tidx", trial_idx, 0); chk("run_rdy", up_if.in_ready, 1);
    endtask

    task automatic wait_done(input bit busy_start);
        bit fired = 0;
        for (int i = 0; i < 400 && run_ad == 0; i++) begin
            @(negedge clk); #1;
            start = 0;
            if (busy_start && !fired && trial_idx == 1 && up_if.in_ready) begin
                start = 1; fired = 1;
            end
        end
        start = 0; src_en = 0;
        chk("run_finished", run_ad, 1);
        chk("run_td_count", run_td, NUM_TRIAL);
        chk("idle_after", busy, 0);
        chk("tidx_end", trial_idx, NUM_TRIAL);
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        int ev_snap;
        bit hit;
        reset = 1; start = 0; abort = 0;
        repeat (2) @(negedge clk);
        chk("rst_filt_rst", filt_rst, 1); chk("rst_busy", busy, 0);
        chk("rst_ready", up_if.in_ready, 0); chk("rst_err_valid", err_valid, 0);
        chk("rst_sig", signal_in, 0); chk("rst_tidx", trial_idx, 0);
        chk("rst_unf", underflow, 0); chk("rst_err_out", err_out, 0);
        reset = 0;

        // streamed run
        prep_run(0); start_run(); wait_done(0);
        chk("t1_unf", underflow, 0);

        // bubbles after the 3rd sample, plus a start while busy
        prep_run(3); start_run(); wait_done(1);
        chk("t2_unf", underflow, 1);

        // start and abort together in IDLE
        @(negedge clk); start = 1; abort = 1;
        @(negedge clk); start = 0; abort = 0;
        chk("sa_busy", busy, 0); chk("sa_filt_rst", filt_rst, 1);
        chk("sa_tidx", trial_idx, NUM_TRIAL); chk("sa_unf", underflow, 1);
        @(negedge clk); chk("sa_busy2", busy, 0);

        // abort after sample 5
        prep_run(0); start_run();
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk); #2;
            if (acc_in_trial == 5) hit = 1;
        end
        chk("ab_reach5", acc_in_trial, 5);
        @(negedge clk); abort = 1; src_en = 0; sb.delete(); ev_snap = ev_total;
        @(negedge clk); abort = 0;
        chk("ab_busy", busy, 0); chk("ab_filt_rst", filt_rst, 1);
        chk("ab_err_valid", err_valid, 0); chk("ab_ready", up_if.in_ready, 0);
        repeat (12) @(negedge clk);
        chk("ab_no_err", ev_total, ev_snap); chk("ab_no_td", run_td, 0);
        chk("ab_no_ad", run_ad, 0);

        // async reset in FLUSH, then a clean run
        prep_run(3); start_run();
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk); #1;
            if (busy && !filt_rst && !up_if.in_ready) hit = 1;
        end
        chk("in_flush", hit, 1);
        chk("flush_unf", underflow, 1);
        #2 reset = 1;
        #1;
        chk("ar_filt_rst", filt_rst, 1); chk("ar_busy", busy, 0);
        chk("ar_ready", up_if.in_ready, 0); chk("ar_err_valid", err_valid, 0);
        chk("ar_err_last", err_last, 0); chk("ar_err_out", err_out, 0);
        chk("ar_sig", signal_in, 0); chk("ar_des", desired_in, 0);
        chk("ar_tidx", trial_idx, 0); chk("ar_td", trial_done, 0);
        chk("ar_ad", all_done, 0); chk("ar_unf", underflow, 0);
        src_en = 0; sb.delete();
        @(negedge clk); reset = 0;
        prep_run(0); start_run(); wait_done(0);
        chk("t4_unf", underflow, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/tflaf_run_ctrl.md
Name: tflaf_run_ctrl

Overview:
- Sequencer in front of tflaf_top.
- Runs NUM_TRIAL independent trials of N samples each. Before each trial it holds the filter in reset; during the trial it streams (x, d) pairs from an upstream valid/ready source into the filter one per cycle.
- Tracks the filter's fixed pipeline latency so each returned error word is tagged valid and aligned to the sample that produced it.
- Flushes the pipeline at the end of each trial and reports per-trial and all-trial completion.

Parameters:
- WIDTH, 16, sample/error word width.
- N, 25000, samples per trial.
- NUM_TRIAL, 50, trials per start command.
- RET, 4, filter latency: cycles from a sample on signal_in to its error on error_d.
- RST_CYC, 2, cycles filt_rst is held before each trial.
- CNT_W, 15, sample counter width; must satisfy 2^CNT_W > N.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- start  in  1  single-cycle pulse; begins a run of NUM_TRIAL trials.
- abort  in  1  synchronous; terminates the run immediately.
- in_valid  in  1  upstream sample available.
- in_ready  out  1  sample accepted this cycle (RUN only).
- in_x  in  WIDTH  input sample.
- in_d  in  WIDTH  desired sample.
- filt_rst  out  1  reset to tflaf_top.
- signal_in  out  WIDTH  registered x to the filter.
- desired_in  out  WIDTH  registered d to the filter.
- error_d_in  in  WIDTH  error_d from the filter.
- err_out  out  WIDTH  registered error word.
- err_valid  out  1  err_out belongs to a real sample.
- err_last  out  1  err_out is for sample N-1 of the trial.
- trial_idx  out  8  current trial, 0-based.
- busy  out  1  state is not IDLE.
- trial_done  out  1  one-cycle pulse at end of each trial's flush.
- all_done  out  1  one-cycle pulse after the last trial.
- underflow  out  1  sticky flag; set if in_valid is low during RUN; cleared on start.

Behaviour:
- Reset values:
  - state = IDLE, filt_rst = 1.
  - signal_in, desired_in, err_out = 0.
  - err_valid, err_last, in_ready, trial_done, all_done, underflow, busy = 0.
  - trial_idx = 0, valid pipe = all zeros.
- States: IDLE, FRST, RUN, FLUSH.
- IDLE:
  - filt_rst = 1; start moves to FRST and clears underflow and trial_idx.
  - start while busy is ignored.
- FRST:
  - filt_rst = 1 for RST_CYC cycles, then RUN with sample count = 0.
  - signal_in and desired_in are driven to 0.
- RUN:
  - filt_rst = 0; in_ready = 1.
  - On an edge with in_valid = 1: register in_x/in_d onto signal_in/desired_in, push 1 into the valid pipe, increment the count.
  - On an edge with in_valid = 0: drive 0/0, push 0 (bubble), do not increment the count, set underflow. The filter itself is never stalled.
  - When the count reaches N (the Nth accept), go to FLUSH at that edge.
- FLUSH:
  - Drive 0/0, push 0 bubbles, for RET+1 cycles.
  - Then pulse trial_done and increment trial_idx.
  - If trial_idx was NUM_TRIAL-1: go to IDLE and pulse all_done in the same cycle as trial_done. Otherwise go to FRST.
- Latency and alignment:
  - The valid pipe is RET deep; a last-sample flag travels alongside each valid bit.
  - At every edge, err_out <= error_d_in and err_valid <= pipe[RET-1].
  - A sample accepted at edge e appears on signal_in after e, and err_valid/err_out for it are asserted after edge e+RET+1.
  - err_last is asserted with err_valid for the Nth sample only.
- Ordering: exactly N err_valid pulses per trial, in acceptance order. The final one arrives at or before trial_done.
- Boundaries:
  - abort in any state: go to IDLE on the next edge, pipe cleared, no trial_done or all_done pulse, filt_rst = 1.
  - abort and start in the same cycle: abort wins.
  - Async reset mid-RUN: all outputs return to reset values immediately.
  - The counter saturation check uses the == N compare only; the counter is never allowed to wrap.

Decomposition:
- Package tflaf_pkg holds:
  - state enum constants (IDLE=2'd0, FRST=2'd1, RUN=2'd2, FLUSH=2'd3);
  - default WIDTH and RET;
  - the trial_idx width.
- Submodule tflaf_valid_pipe: a RET-deep shift register carrying {valid, last}, with synchronous clear (abort) and async reset.

Test Plan (N=8, RET=4, NUM_TRIAL=2, RST_CYC=2):
- Streamed run: start, then in_valid held 1 with x = 1..8 → filt_rst low 2 cycles after start; signal_in = 1..8 on consecutive cycles; err_valid pulses exactly 8 times per trial, each 5 cycles after its accept edge; err_last on the 8th; trial_done twice; all_done with the second; trial_idx = 0 then 1; underflow = 0.
- Bubble: in_valid dropped for 2 cycles after the 3rd sample → zeros driven 2 cycles, underflow = 1, still exactly 8 err_valid pulses, with a 2-cycle gap in err_valid.
- Abort mid-RUN after sample 5 → IDLE next edge; filt_rst = 1; no further err_valid; no trial_done; busy = 0.
- Async reset asserted mid-FLUSH → all outputs at reset values without a clock edge; a later start behaves like the first test.
- start while busy, and abort with start in the same IDLE cycle → both ignored (state unchanged), counts unaffected.
